// File: rtl/cva6_refill_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cva6_refill_read_arbiter
//  Brief    : Shares one refill memory read channel between the I$ (source 0)
//             and the D$ (source 1). Round-robin grant with lock-until-accept,
//             source tag in the ID MSB, per-source outstanding limits,
//             zero-latency response routing and a drain/idle handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module cva6_refill_read_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // per-source request side
  input  logic [1:0]                         src_req_valid_i,
  output logic [1:0]                         src_req_ready_o,
  input  logic [1:0][ADDR_WIDTH-1:0]         src_req_addr_i,
  input  logic [1:0][ID_WIDTH-1:0]           src_req_id_i,
  // memory request side
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
  output logic [ID_WIDTH:0]                  mem_req_id_o,
  // memory response side
  input  logic                               mem_resp_valid_i,
  output logic                               mem_resp_ready_o,
  input  logic [ID_WIDTH:0]                  mem_resp_id_i,
  input  logic [DATA_WIDTH-1:0]              mem_resp_data_i,
  input  logic                               mem_resp_last_i,
  // per-source response side
  output logic [1:0]                         src_resp_valid_o,
  input  logic [1:0]                         src_resp_ready_i,
  output logic [ID_WIDTH-1:0]                src_resp_id_o,
  output logic [DATA_WIDTH-1:0]              src_resp_data_o,
  output logic                               src_resp_last_o,
  // flush sequencing
  input  logic                               drain_i,
  output logic                               idle_o,
  output logic                               err_o
);

  localparam int unsigned           c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_lock_src;
  logic       r_rr;
  logic       r_err;

  logic [1:0] w_elig;
  logic [1:0] w_cnt_room;
  logic [1:0] w_cnt_zero;
  logic [1:0] w_inc;
  logic [1:0] w_dec;
  logic       w_gnt_valid;
  logic       w_sel;
  logic       w_req_hs;
  logic       w_rsp_src;
  logic       w_rsp_done;

  // A source may compete only with room left in its counter and no drain pending
  assign w_elig = src_req_valid_i & w_cnt_room & {2{~drain_i}};

  // Grant selection and next state: IDLE picks (rr breaks ties), LOCKED holds
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_valid = 1'b0;
    w_sel       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_gnt_valid = 1'b1;
          w_sel       = (&w_elig) ? r_rr : w_elig[1];
          if (!mem_req_ready_i) begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        w_gnt_valid = 1'b1;
        w_sel       = r_lock_src;
        if (mem_req_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_req_hs           = w_gnt_valid & mem_req_ready_i;
  assign mem_req_valid_o    = w_gnt_valid;
  assign mem_req_addr_o     = src_req_addr_i[w_sel];
  assign mem_req_id_o       = {w_sel, src_req_id_i[w_sel]};
  assign src_req_ready_o[0] = w_gnt_valid & mem_req_ready_i & ~w_sel;
  assign src_req_ready_o[1] = w_gnt_valid & mem_req_ready_i &  w_sel;

  // State, lock owner and round-robin pointer; pointer flips away from the winner
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_lock_src <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_gnt_valid && !mem_req_ready_i) begin
        r_lock_src <= w_sel;
      end
      if (w_req_hs) begin
        r_rr <= ~w_sel;
      end
    end
  end

  // Response routing: the ID MSB names the requester, remaining bits pass through
  assign w_rsp_src        = mem_resp_id_i[ID_WIDTH];
  assign src_resp_valid_o = {mem_resp_valid_i & w_rsp_src, mem_resp_valid_i & ~w_rsp_src};
  assign mem_resp_ready_o = src_resp_ready_i[w_rsp_src];
  assign src_resp_id_o    = mem_resp_id_i[ID_WIDTH-1:0];
  assign src_resp_data_o  = mem_resp_data_i;
  assign src_resp_last_o  = mem_resp_last_i;
  assign w_rsp_done       = mem_resp_valid_i & src_resp_ready_i[w_rsp_src] & mem_resp_last_i;

  assign w_inc = {2{w_req_hs}}   & {w_sel, ~w_sel};
  assign w_dec = {2{w_rsp_done}} & {w_rsp_src, ~w_rsp_src};

  generate
    for (genvar s = 0; s < 2; s++) begin : g_cnt
      logic [c_cnt_w-1:0] r_cnt;

      // Outstanding reads: +1 on accept, -1 on last beat, floor at zero
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (w_inc[s] && !w_dec[s]) begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end else if (w_dec[s] && !w_inc[s] && (r_cnt != '0)) begin
          r_cnt <= r_cnt - c_cnt_w'(1);
        end
      end

      assign w_cnt_room[s] = (r_cnt < c_cnt_max);
      assign w_cnt_zero[s] = (r_cnt == '0);
    end
  endgenerate

  // Sticky flag for a completion that no outstanding read accounts for
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (|(w_dec & w_cnt_zero)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o  = r_err;
  assign idle_o = (r_state == ST_IDLE) & (&w_cnt_zero);

endmodule
`default_nettype wire

// File: tb/tb_cva6_refill_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cva6_refill_read_arbiter
//  Brief    : Directed vector bench for cva6_refill_read_arbiter
//             (MAX_OUTSTANDING = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_refill_read_arbiter;

  localparam logic [63:0] c_a0  = 64'h0000_0000_8000_0040;
  localparam logic [63:0] c_a1  = 64'h0000_0000_9000_0080;
  localparam logic [3:0]  c_id0 = 4'h3;
  localparam logic [3:0]  c_id1 = 4'hA;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        src_req_valid;
  logic [1:0]        src_req_ready;
  logic [1:0][63:0]  src_req_addr;
  logic [1:0][3:0]   src_req_id;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_req_addr;
  logic [4:0]        mem_req_id;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [4:0]        mem_resp_id;
  logic [127:0]      mem_resp_data;
  logic              mem_resp_last;
  logic [1:0]        src_resp_valid;
  logic [1:0]        src_resp_ready;
  logic [3:0]        src_resp_id;
  logic [127:0]      src_resp_data;
  logic              src_resp_last;
  logic              drain;
  logic              idle;
  logic              err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign src_req_addr[0] = c_a0;
  assign src_req_addr[1] = c_a1;
  assign src_req_id[0]   = c_id0;
  assign src_req_id[1]   = c_id1;

  cva6_refill_read_arbiter #(
    .ADDR_WIDTH      (64),
    .ID_WIDTH        (4),
    .DATA_WIDTH      (128),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_req_valid_i  (src_req_valid),
    .src_req_ready_o  (src_req_ready),
    .src_req_addr_i   (src_req_addr),
    .src_req_id_i     (src_req_id),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_id_o     (mem_req_id),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_ready_o (mem_resp_ready),
    .mem_resp_id_i    (mem_resp_id),
    .mem_resp_data_i  (mem_resp_data),
    .mem_resp_last_i  (mem_resp_last),
    .src_resp_valid_o (src_resp_valid),
    .src_resp_ready_i (src_resp_ready),
    .src_resp_id_o    (src_resp_id),
    .src_resp_data_o  (src_resp_data),
    .src_resp_last_o  (src_resp_last),
    .drain_i          (drain),
    .idle_o           (idle),
    .err_o            (err)
  );

  typedef struct {
    logic       rst;
    logic       chk;
    logic [1:0] rv;
    logic       mrdy;
    logic       drn;
    logic       pv;
    logic [4:0] pid;
    logic       plast;
    logic [1:0] prdy;
    logic [1:0] e_rdy;
    logic       e_mv;
    logic       e_src;
    logic [1:0] e_pv;
    logic       e_prdy;
    logic       e_idle;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst_v, input logic chk, input logic [1:0] rv, input logic mrdy,
    input logic drn, input logic pv, input logic [4:0] pid, input logic plast,
    input logic [1:0] prdy, input logic [1:0] e_rdy, input logic e_mv,
    input logic e_src, input logic [1:0] e_pv, input logic e_prdy,
    input logic e_idle, input logic e_err);
    vec_t v;
    v.rst = rst_v;   v.chk = chk;     v.rv = rv;       v.mrdy = mrdy;
    v.drn = drn;     v.pv = pv;       v.pid = pid;     v.plast = plast;
    v.prdy = prdy;   v.e_rdy = e_rdy; v.e_mv = e_mv;   v.e_src = e_src;
    v.e_pv = e_pv;   v.e_prdy = e_prdy; v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst            = v.rst;
    src_req_valid  = v.rv;
    mem_req_ready  = v.mrdy;
    drain          = v.drn;
    mem_resp_valid = v.pv;
    mem_resp_id    = v.pid;
    mem_resp_last  = v.plast;
    src_resp_ready = v.prdy;
    mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check(input vec_t v, input int idx);
    logic [4:0]  exp_id;
    logic [63:0] exp_addr;
    logic        ok;
    exp_id   = {v.e_src, (v.e_src ? c_id1 : c_id0)};
    exp_addr = v.e_src ? c_a1 : c_a0;
    ok = (src_req_ready == v.e_rdy) && (mem_req_valid == v.e_mv) &&
         (!v.e_mv || ((mem_req_id == exp_id) && (mem_req_addr == exp_addr))) &&
         (src_resp_valid == v.e_pv) && (mem_resp_ready == v.e_prdy) &&
         (src_resp_id == v.pid[3:0]) && (src_resp_data == mem_resp_data) &&
         (src_resp_last == v.plast) && (idle == v.e_idle) && (err == v.e_err);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL vec%0d: actual rdy=%b mv=%b id=%h addr=%h pv=%b prdy=%b rid=%h idle=%b err=%b | required rdy=%b mv=%b id=%h addr=%h pv=%b prdy=%b rid=%h idle=%b err=%b",
               idx, src_req_ready, mem_req_valid, mem_req_id, mem_req_addr, src_resp_valid,
               mem_resp_ready, src_resp_id, idle, err, v.e_rdy, v.e_mv, exp_id, exp_addr,
               v.e_pv, v.e_prdy, v.pid[3:0], v.e_idle, v.e_err);
    end
  endtask

  task automatic check_bit(input string name, input logic [1:0] act, input logic [1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: actual %b required %b", name, act, req);
    end
  endtask

  initial begin
    vec_t v;
    logic prev;

    rst = 1'b1; src_req_valid = '0; mem_req_ready = 1'b1; drain = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_last = 1'b0;
    src_resp_ready = 2'b11; mem_resp_data = '0;
    @(negedge clk);
    @(negedge clk);

    //           rst chk rv    mrdy drn pv pid    last prdy   e_rdy e_mv src e_pv e_prdy idle err
    // single I$ read and its completion
    tbl.push_back(mk(0,1, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b00,1,0, 1,5'h03,1,2'b01, 2'b00,0,0, 2'b01,1, 0,0));
    tbl.push_back(mk(0,1, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    // alternation from reset, then both counters at the limit
    tbl.push_back(mk(1,0, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b10,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b10,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 1,5'h1A,1,2'b10, 2'b00,0,0, 2'b10,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 1,5'h03,0,2'b01, 2'b10,1,1, 2'b01,1, 0,0));
    tbl.push_back(mk(0,1, 2'b00,1,0, 1,5'h03,1,2'b10, 2'b00,0,0, 2'b01,0, 0,0));
    // D$ locked for three stalled cycles while I$ is also requesting
    tbl.push_back(mk(1,0, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b11,0,0, 0,5'h00,0,2'b11, 2'b00,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,0,0, 0,5'h00,0,2'b11, 2'b00,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,0,0, 0,5'h00,0,2'b11, 2'b00,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,0, 0,5'h00,0,2'b11, 2'b10,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 0,0));
    // outstanding limit of two on I$
    tbl.push_back(mk(1,0, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 1,5'h03,1,2'b01, 2'b00,0,0, 2'b01,1, 0,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 0,0));
    // drain while locked on D$ with two I$ reads in flight
    tbl.push_back(mk(1,0, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 1,0));
    tbl.push_back(mk(0,1, 2'b01,1,0, 0,5'h00,0,2'b11, 2'b01,1,0, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b10,0,0, 0,5'h00,0,2'b11, 2'b00,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,0,1, 0,5'h00,0,2'b11, 2'b00,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,1, 0,5'h00,0,2'b11, 2'b10,1,1, 2'b00,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,1, 1,5'h1A,1,2'b11, 2'b00,0,0, 2'b10,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,1, 1,5'h03,1,2'b11, 2'b00,0,0, 2'b01,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,1, 1,5'h03,1,2'b11, 2'b00,0,0, 2'b01,1, 0,0));
    tbl.push_back(mk(0,1, 2'b11,1,1, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));
    // unexpected D$ completion sets the sticky error
    tbl.push_back(mk(0,1, 2'b00,1,0, 1,5'h15,1,2'b10, 2'b00,0,0, 2'b10,1, 1,0));
    tbl.push_back(mk(0,1, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,1));
    tbl.push_back(mk(0,1, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,1));
    tbl.push_back(mk(1,0, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,1));
    tbl.push_back(mk(0,1, 2'b00,1,0, 0,5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 1,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk) check(tbl[i], i);
    end

    // Sustained contention with completions retiring the previous grant each cycle
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = mk(0,0, 2'b11,1,0, (i > 0), {prev, (prev ? c_id1 : c_id0)},1,2'b11,
             2'b00,0,0, 2'b00,1, 0,0);
      drive(v);
      #1;
      check_bit($sformatf("alt%0d", i), src_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      prev = (i % 2 == 1);
    end
    @(negedge clk);
    v = mk(0,0, 2'b00,1,0, 1, {1'b1, c_id1},1,2'b11, 2'b00,0,0, 2'b00,1, 0,0);
    drive(v);
    #1;
    check_bit("alt_final_rsp", src_resp_valid, 2'b10);
    check_bit("alt_not_idle", {1'b0, idle}, 2'b00);
    @(negedge clk);
    v = mk(0,0, 2'b00,1,0, 0, 5'h00,0,2'b11, 2'b00,0,0, 2'b00,1, 0,0);
    drive(v);
    #1;
    check_bit("alt_idle", {err, idle}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
